// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_unit_pkg
//   Shared constants for the iterative multiply/divide unit: operation
//   encodings (kept in step with the ALU operation constants), FSM state
//   encodings and the default operand width.
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

   localparam int MDU_WIDTH = 32;

   // Operation select carried on iOp; codes 6 and 7 are ignored by the unit.
   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_step
//   One restoring-division step, purely combinational.
//   rem_in  : shifted partial remainder ({previous remainder, next dividend bit})
//   divisor : divisor magnitude
//   rem_out : remainder after the trial subtraction (restored if it went negative)
//   q_bit   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module mdu_div_step
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   // The subtraction only "sticks" when it does not borrow; the surviving
   // remainder is always below the divisor, so it fits in WIDTH bits.
   assign q_bit   = (rem_in >= {1'b0, divisor});
   assign rem_out = WIDTH'(rem_in - {1'b0, divisor & {WIDTH{q_bit}}});

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit that owns HI/LO. Shift-add multiplier and
//   restoring divider, one bit per cycle, followed by one sign-fixup cycle.
// Ports
//   iCLK, iRST  : clock, synchronous active-high reset (aborts any op)
//   iStart, iOp : op request and code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   iA, iB      : operands, latched at issue
//   oBusy       : pipeline stall, includes the issue cycle of a mul/div
//   oDone       : one-cycle pulse after HI/LO are written by a mul/div
//   oDivByZero  : qualifies oDone; the divisor was zero
//   oHI, oLO    : architectural HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [2:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oBusy,
   output logic             oDone,
   output logic             oDivByZero,
   output logic [WIDTH-1:0] oHI,
   output logic [WIDTH-1:0] oLO
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   mdu_state_e         state, state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: low half is quotient
   logic [WIDTH-1:0]   operand;  // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   rem;
   logic               neg_lo, neg_hi, div_zero, is_div;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q, dbz_q;

   // Issue decode: magnitudes are taken only for the signed ops.
   logic             start_md, signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign start_md  = iStart && (iOp <= MDU_DIVU);
   assign signed_op = (iOp == MDU_MULT) || (iOp == MDU_DIV);
   assign a_neg     = signed_op && iA[WIDTH-1];
   assign b_neg     = signed_op && iB[WIDTH-1];
   assign a_mag     = a_neg ? -iA : iA;
   assign b_mag     = b_neg ? -iB : iB;

   // One multiply step: add the multiplicand into the upper half when the
   // current multiplier bit is set, then shift the whole accumulator right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;

   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, operand} & {(WIDTH+1){acc[0]}});
   assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

   logic [WIDTH-1:0] div_rem_nxt;
   logic             div_q_bit;

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  ({rem, acc[WIDTH-1]}),
      .divisor (operand),
      .rem_out (div_rem_nxt),
      .q_bit   (div_q_bit)
   );

   // NOTE: every signal written here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:       if (start_md) state_nxt = (iOp[1]) ? S_DIV : S_MUL;
         S_MUL, S_DIV: if (count == LAST) state_nxt = S_FIX;
         S_FIX:        state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state    <= S_IDLE;
         count    <= '0;
         acc      <= '0;
         operand  <= '0;
         rem      <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         is_div   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (iStart && iOp == MDU_MTHI) hi_q <= iA;
               if (iStart && iOp == MDU_MTLO) lo_q <= iA;
               if (start_md) begin
                  count    <= '0;
                  is_div   <= iOp[1];
                  neg_lo   <= a_neg ^ b_neg;
                  neg_hi   <= a_neg;
                  div_zero <= iOp[1] && (iB == '0);
                  rem      <= '0;
                  if (iOp[1]) begin
                     acc     <= {{WIDTH{1'b0}}, a_mag};
                     operand <= b_mag;
                  end else begin
                     acc     <= {{WIDTH{1'b0}}, b_mag};
                     operand <= a_mag;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_nxt;
               if (count != LAST) count <= count + CW'(1);
            end
            S_DIV: begin
               acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_q_bit};
               rem            <= div_rem_nxt;
               if (count != LAST) count <= count + CW'(1);
            end
            S_FIX: begin
               done_q <= 1'b1;
               if (is_div) begin
                  // Zero divisor: all-ones quotient; remainder is the dividend.
                  lo_q  <= div_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
                  hi_q  <= neg_hi ? -rem : rem;
                  dbz_q <= div_zero;
               end else begin
                  {hi_q, lo_q} <= neg_lo ? -acc : acc;
               end
            end
            default: ;
         endcase
      end
   end

   assign oBusy      = (state != S_IDLE) || start_md;
   assign oDone      = done_q;
   assign oDivByZero = dbz_q;
   assign oHI        = hi_q;
   assign oLO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit (WIDTH=32): directed vector table,
//   hand-written sequences for MTHI/MTLO, reset abort and ops issued while
//   busy, then randomized ops against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W       = 32;
   localparam int LAT     = W + 2;  // done cycle, counted from the issue cycle
   localparam int BUDGET  = 80;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, dbz;
   logic [W-1:0]  hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .iCLK       (clk),
      .iRST       (rst),
      .iStart     (start),
      .iOp        (op),
      .iA         (a),
      .iB         (b),
      .oBusy      (busy),
      .oDone      (done),
      .oDivByZero (dbz),
      .oHI        (hi),
      .oLO        (lo)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Reference model: {div_by_zero, HI, LO} from ordinary integer arithmetic.
   function automatic logic [64:0] ref_md(input logic [2:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
      longint      sa, sb, sq, sr;
      logic [63:0] ua, ub, up;
      sa = longint'($signed(fa));
      sb = longint'($signed(fb));
      ua = {32'd0, fa};
      ub = {32'd0, fb};
      ref_md = '0;
      case (f_op)
         3'd0: begin up = 64'(sa * sb); ref_md = {1'b0, up}; end
         3'd1: begin up = ua * ub;      ref_md = {1'b0, up}; end
         3'd2: begin
            if (fb == 0) ref_md = {1'b1, fa, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               ref_md = {1'b0, sr[31:0], sq[31:0]};
            end
         end
         3'd3: begin
            if (fb == 0) ref_md = {1'b1, fa, 32'hFFFF_FFFF};
            else ref_md = {1'b0, fa % fb, fa / fb};
         end
         default: ref_md = '0;
      endcase
   endfunction

   // Issue one op in cycle 0 and watch until oDone (bounded). Optionally
   // injects a second iStart in cycle inj_cyc. Operand inputs are scrambled
   // after issue to show they are latched.
   task automatic run_op(input logic [2:0] t_op, input logic [31:0] ta, input logic [31:0] tb,
                         input int inj_cyc, input logic [2:0] inj_op,
                         output int busy_cnt, output int done_cyc, output logic dbz_at_done,
                         output logic done_again, output logic stray_dbz);
      busy_cnt    = 0;
      done_cyc    = -1;
      dbz_at_done = 1'b0;
      stray_dbz   = 1'b0;
      @(negedge clk);
      start = 1'b1; op = t_op; a = ta; b = tb;
      #1;
      if (busy) busy_cnt++;
      for (int c = 1; c <= BUDGET && done_cyc < 0; c++) begin
         @(negedge clk);
         start = (c == inj_cyc);
         op    = inj_op;
         a     = $urandom;
         b     = $urandom;
         #1;
         if (busy) busy_cnt++;
         if (dbz && !done) stray_dbz = 1'b1;
         if (done) begin
            done_cyc    = c;
            dbz_at_done = dbz;
         end
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      done_again = done;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   vec_t vecs[10];

   task automatic check_op(input string tag, input logic [2:0] t_op, input logic [31:0] ta,
                           input logic [31:0] tb, input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input logic e_dbz, input int inj_cyc, input logic [2:0] inj_op);
      int   bc, dc;
      logic dz, da, sd;
      run_op(t_op, ta, tb, inj_cyc, inj_op, bc, dc, dz, da, sd);
      check({tag, " busy_cycles"}, 64'(bc), 64'(LAT));
      check({tag, " done_cycle"},  64'(dc), 64'(LAT));
      check({tag, " hi"},          64'(hi), 64'(e_hi));
      check({tag, " lo"},          64'(lo), 64'(e_lo));
      check({tag, " div_by_zero"}, 64'(dz), 64'(e_dbz));
      check({tag, " done_pulse"},  64'(da), 64'(0));
      check({tag, " stray_dbz"},   64'(sd), 64'(0));
   endtask

   initial begin
      logic [64:0] exp_r;
      logic [2:0]  r_op;
      logic [31:0] ra, rb;
      logic        seen_done;

      vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[2] = '{3'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[3] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[4] = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
      vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6] = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
      vecs[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[8] = '{3'd2, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
      vecs[9] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset hi",   64'(hi),   64'(0));
      check("reset lo",   64'(lo),   64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset dbz",  64'(dbz),  64'(0));

      // MTHI / MTLO complete at the issue edge and never stall.
      @(negedge clk);
      start = 1'b1; op = MDU_MTHI; a = 32'h0000_1234;
      #1; check("mthi busy issue", 64'(busy), 64'(0));
      @(negedge clk);
      start = 1'b0; a = '0;
      #1;
      check("mthi hi",   64'(hi),   64'h1234);
      check("mthi busy", 64'(busy), 64'(0));
      check("mthi done", 64'(done), 64'(0));
      @(negedge clk);
      start = 1'b1; op = MDU_MTLO; a = 32'h0000_5678;
      #1; check("mtlo busy issue", 64'(busy), 64'(0));
      @(negedge clk);
      start = 1'b0;
      #1;
      check("mtlo lo", 64'(lo), 64'h5678);
      check("mtlo hi", 64'(hi), 64'h1234);

      // Op code 6 is ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'h1;
      #1; check("op6 busy", 64'(busy), 64'(0));
      @(negedge clk);
      start = 1'b0;
      #1;
      check("op6 hi", 64'({hi, lo}), 64'h0000_1234_0000_5678);

      // Reset in busy cycle 10 of a DIV aborts it.
      @(negedge clk);
      start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst   = (c == 10);
      end
      #1; check("abort busy before reset", 64'(busy), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'(0));
      check("abort hilo", 64'({hi, lo}), 64'(0));
      check("abort done", 64'(done), 64'(0));
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      check("abort quiet", 64'(seen_done), 64'(0));
      check_op("post_abort_mult", MDU_MULT, 32'd12, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFC4, 1'b0, -1, 3'd0);

      for (int i = 0; i < 10; i++)
         check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dbz, -1, 3'd0);

      // Requests arriving while busy are dropped; the DIV result survives.
      check_op("div_inj_mtlo", MDU_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5, MDU_MTLO);
      check_op("div_inj_mthi", MDU_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 7, MDU_MTHI);
      check_op("div_inj_mult", MDU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 6, MDU_MULT);

      for (int i = 0; i < 40; i++) begin
         r_op = 3'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            2:       ra = $urandom_range(0, 255);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'h0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 255);
            default: rb = $urandom;
         endcase
         exp_r = ref_md(r_op, ra, rb);
         check_op($sformatf("rnd%0d op%0d a=%h b=%h", i, r_op, ra, rb), r_op, ra, rb,
                  exp_r[63:32], exp_r[31:0], exp_r[64], -1, 3'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
